// File: rtl/fsm_bit_serializer.sv
// Parallel-to-serial feeder for the Mealy FSM's serial input.
// A one-word holding register lets consecutive words stream with no idle gap.
module fsm_bit_serializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BIT_CYCLES = 1,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [DATA_WIDTH-1:0] In_Data,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  output logic                  Ser_Out,
  output logic                  Ser_Active,
  output logic                  Word_Done
);

  localparam int unsigned BW = $clog2(DATA_WIDTH);
  localparam int unsigned CW = $clog2(BIT_CYCLES) + 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state, state_next;
  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BW-1:0]         bit_cnt;
  logic [CW-1:0]         cyc_cnt;
  logic                  accept, period_end, word_end, load, advance;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_on(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // A load happens from IDLE or at the last edge of a word, so back-to-back words never idle.
  always_comb begin
    period_end = (state == SHIFT) && (cyc_cnt == CYC_LAST);
    word_end   = period_end && (bit_cnt == BIT_LAST);
    load       = hold_valid && ((state == IDLE) || word_end);
    advance    = period_end && !word_end;
    state_next = state;
    if (load)          state_next = SHIFT;
    else if (word_end) state_next = IDLE;
  end

  always_comb begin
    In_Ready   = Reset_n & ~hold_valid;
    Ser_Active = (state == SHIFT);
    accept     = In_Valid & In_Ready;
  end

  // shreg holds the bits not yet driven; Ser_Out is always the registered current bit.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      cyc_cnt    <= '0;
      Ser_Out    <= IDLE_LEVEL;
      Word_Done  <= 1'b0;
    end else begin
      Word_Done <= word_end;

      if (accept) begin
        hold_valid <= 1'b1;
        hold_data  <= In_Data;
      end else if (load) begin
        hold_valid <= 1'b0;
      end

      if (load) begin
        shreg   <= shift_on(hold_data);
        Ser_Out <= first_bit(hold_data);
        bit_cnt <= '0;
        cyc_cnt <= '0;
      end else if (advance) begin
        shreg   <= shift_on(shreg);
        Ser_Out <= first_bit(shreg);
        bit_cnt <= bit_cnt + 1'b1;
        cyc_cnt <= '0;
      end else if (word_end) begin
        Ser_Out <= IDLE_LEVEL;
        bit_cnt <= '0;
        cyc_cnt <= '0;
      end else if (state == SHIFT) begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
    end
  end

endmodule
